// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request bus between the pipeline (master) and the SRAM controller (slave).
interface sram_controller_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;

    modport master (output mem_r_en, mem_w_en, addr, wr_data,
                    input  rd_data, ready);
    modport slave  (input  mem_r_en, mem_w_en, addr, wr_data,
                    output rd_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two 16-bit SRAM transfers; ready stays low until done.
//   state | meaning
//   IDLE  | no access; a request moves to LO and latches the op
//   LO    | low half-word on the bus for HALF_CYCLES cycles
//   HI    | high half-word on the bus for HALF_CYCLES cycles
//   DONE  | one cycle, ready high, rd_data valid
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          HALF_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam int             CW   = $clog2(HALF_CYCLES) + 1;
    localparam int             WAW  = SRAM_AW - 1;
    localparam logic [CW-1:0]  LAST = CW'(HALF_CYCLES - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_wr;
    logic [31:0]        rd_q;
    logic [SRAM_AW-1:0] addr_hold;
    logic [SRAM_DW-1:0] dq_hold;
    logic [WAW-1:0]     word;
    logic               active;
    logic               last;

    assign word   = WAW'((bus.addr - BASE_ADDR) >> 2);
    assign active = (state == LO) || (state == HI);
    assign last   = (cnt == LAST);

    // Address and data follow the live inputs during LO/HI and hold otherwise.
    always_comb begin
        sram_addr   = addr_hold;
        sram_dq_out = dq_hold;
        case (state)
            LO: begin
                sram_addr   = {word, 1'b0};
                sram_dq_out = bus.wr_data[15:0];
            end
            HI: begin
                sram_addr   = {word, 1'b1};
                sram_dq_out = bus.wr_data[31:16];
            end
            default: ;
        endcase
    end

    assign sram_we_n   = !(active && op_wr);
    assign sram_dq_oe  = active && op_wr;
    assign bus.rd_data = rd_q;
    assign bus.ready   = ((state == IDLE) && !bus.mem_r_en && !bus.mem_w_en) ||
                         (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            rd_q      <= '0;
            addr_hold <= '0;
            dq_hold   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_r_en || bus.mem_w_en) begin
                        state <= LO;
                        cnt   <= '0;
                        op_wr <= bus.mem_w_en;
                    end
                end
                LO: begin
                    addr_hold <= sram_addr;
                    dq_hold   <= sram_dq_out;
                    if (last) begin
                        state <= HI;
                        cnt   <= '0;
                        if (!op_wr) rd_q[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HI: begin
                    addr_hold <= sram_addr;
                    dq_hold   <= sram_dq_out;
                    if (last) begin
                        state <= DONE;
                        cnt   <= '0;
                        if (!op_wr) rd_q[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage responder for the pipeline's load/store requests. It accepts a 32-bit word access (mem_r_en / mem_w_en, ALU address, store data) from the EXE/MEM side. It performs the access as two sequential 16-bit half-word transfers on the external SRAM and holds ready low until the access completes; the pipeline uses ready low to freeze all stage registers. It sits between the MEM-stage request signals and the board SRAM pins.

## Interface
- HALF_CYCLES, 2: cycles each half-word phase is held on the SRAM bus (≥1)
- BASE_ADDR, 1024: byte address mapped to SRAM word 0
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_r_en  in  1  load request; held stable while ready=0
- mem_w_en  in  1  store request; held stable while ready=0
- addr  in  32  byte address from ALU, word aligned
- wr_data  in  32  store data
- rd_data  out  32  load data, registered
- ready  out  1  access complete / no access pending
- sram_addr  out  18  SRAM half-word address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  16  read data from pad
- sram_we_n  out  1  SRAM write enable, active low

## Operation
- States: IDLE, LO, HI, DONE. Counter cnt, width clog2(HALF_CYCLES)+1.
- IDLE: if mem_r_en|mem_w_en → LO, cnt=0, latch op (write if mem_w_en, else read). Both asserted: treated as write.
- LO: cnt increments each cycle. At cnt==HALF_CYCLES-1 → HI, cnt=0.
- HI: cnt increments each cycle. At cnt==HALF_CYCLES-1 → DONE.
- DONE: one cycle, then → IDLE unconditionally. A request still asserted in the following IDLE cycle is a new access.
- Address: eff = addr − BASE_ADDR (32-bit wrap); word = eff[18:2]; sram_addr = {word, 1'b0} in LO and {word, 1'b1} in HI. In IDLE/DONE, sram_addr keeps its last value.
- Write: sram_dq_oe=1 and sram_we_n=0 throughout LO and HI. sram_dq_out = wr_data[15:0] in LO and wr_data[31:16] in HI.
- Read: sram_we_n=1, sram_dq_oe=0. On the clock edge ending the last LO cycle, rd_data[15:0] ← sram_dq_in. On the edge ending the last HI cycle, rd_data[31:16] ← sram_dq_in. rd_data holds its value until the next read overwrites it; writes never change it.
- ready (combinational) = (state==IDLE & ~mem_r_en & ~mem_w_en) | state==DONE.
- sram_we_n and sram_dq_oe are combinational decodes of state and op.

## Timing
- Reset values: state IDLE, cnt 0, rd_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, ready 1 (absent a request).
- Request first seen in cycle 0 (IDLE): ready=0 combinationally in that same cycle.
- LO occupies cycles 1..H, HI occupies cycles H+1..2H, and DONE is cycle 2H+1 with ready=1. Total: 2H+2 cycles from request to return to IDLE.
- rd_data is valid in the DONE cycle, in time for the MEM/WB register edge at the end of that cycle.
- rst asserted mid-access: immediate return to reset values. The SRAM contents may hold a partial write; this is accepted.
- Inputs changing while ready=0 is a protocol violation; addr and wr_data are sampled combinationally during LO/HI, not latched.

## Structure
- Shared package: state enum (IDLE, LO, HI, DONE), SRAM_AW=18, SRAM_DW=16, default BASE_ADDR.
- Single module; no RTL sub-module. The bench provides a behavioural sram_model (2^18×16, write on sram_we_n low at posedge, asynchronous read).

## Test plan
- Idle: no requests for 10 cycles → ready=1 every cycle, sram_we_n=1, sram_dq_oe=0.
- Store: H=2, addr=1024, wr_data=0xDEADBEEF → ready low cycles 0–4, high in cycle 5. Model holds word0=0xBEEF, word1=0xDEAD; sram_we_n low for exactly 4 cycles.
- Load: read addr=1024 after the store → rd_data=0xDEADBEEF in the DONE cycle, ready high in cycle 5. Hold rd_data through a following store to addr=1028.
- Address map: store 0x12345678 to addr=1032 → model words 4=0x5678 and 5=0x1234; words 0–3 unchanged.
- Back-to-back: load held across DONE → a second access starts in the next IDLE cycle, ready=0 again, and two complete accesses occur in 12 cycles.
- Reset mid-store: assert rst in cycle 2 of a store → sram_we_n=1, state IDLE, rd_data=0 immediately. A subsequent load completes normally in 6 cycles. Repeat the store and load with H=1, expecting 4-cycle accesses.
